// File: rtl/branch_resolve_unit_pkg.sv
// Shared types for the branch resolve unit and its neighbours.
//   BR_NUM_IDS / BR_ID_W : branch tag space, also used by rename/dispatch
//   bru_pred_entry_t     : prediction captured at dispatch, one per tag
//   bru_upd_rec_t        : training record sent to the BTB/BHT
package branch_resolve_unit_pkg;

    localparam int BR_NUM_IDS = 4;
    localparam int BR_ID_W    = $clog2(BR_NUM_IDS);

    typedef struct packed {
        logic        valid;
        logic        pred_taken;
        logic [31:0] pred_target;
    } bru_pred_entry_t;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] target;
        logic        taken;
        logic        mispred;
    } bru_upd_rec_t;

    // A target mismatch only counts when both sides agree the branch is taken.
    // A CSR redirect always counts as a misprediction.
    function automatic logic bru_is_mispred(input bru_pred_entry_t e,
                                            input logic        taken,
                                            input logic [31:0] addr,
                                            input logic        csr);
        return csr | (e.pred_taken != taken) |
               (taken & e.pred_taken & (e.pred_target != addr));
    endfunction

endpackage

// File: rtl/branch_resolve_unit_upd_fifo.sv
// bru_upd_fifo: generic synchronous FIFO, element type T, DEPTH entries
// (power of two, >= 2).
//   clk, rst_n    : clock, async active-low reset
//   push_i        : write request; accepted when not full, or when a pop
//                   happens in the same cycle
//   pop_i         : read request; ignored when empty
//   wdata_i       : element to write
//   rdata_o       : head element, read straight from storage
//   full_o/empty_o: occupancy flags
module bru_upd_fifo #(
    parameter type T     = logic,
    parameter int  DEPTH = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic push_i,
    input  logic pop_i,
    input  T     wdata_i,
    output T     rdata_o,
    output logic full_o,
    output logic empty_o
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    T              mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q, rd_ptr_q;
    logic [CW-1:0] cnt_q;
    logic          do_push, do_pop;

    assign full_o  = (cnt_q == CW'(DEPTH));
    assign empty_o = (cnt_q == '0);
    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);
    assign rdata_o = mem_q[rd_ptr_q];

    // Storage is cleared on reset so the head outputs read 0 out of reset.
    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + 1'b1;
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + 1'b1;
            cnt_q <= cnt_q + CW'(do_push) - CW'(do_pop);
        end
    end

endmodule

// File: rtl/branch_resolve_unit.sv
// branch_resolve_unit: checks resolved control transfers against the
// prediction recorded at dispatch, raises a registered redirect on a
// misprediction and queues predictor training records.
//   disp_*         : dispatch-time prediction, written into the tag table
//   res_*          : resolution record from the branch/CSR execution unit
//   global_flush   : clears the tag table, cancels the redirect being formed
//   redirect_*     : one-cycle front-end redirect, flush_branch_id = tag
//   upd_*          : training FIFO head with valid/ready handshake
//   drop_cnt       : saturating count of training records lost to a full FIFO
module branch_resolve_unit
    import branch_resolve_unit_pkg::*;
#(
    parameter  int NUM_BR_IDS = BR_NUM_IDS,
    parameter  int UPD_DEPTH  = 4,
    parameter  int DROP_CNT_W = 8,
    localparam int ID_W       = $clog2(NUM_BR_IDS)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  disp_valid,
    input  logic [ID_W-1:0]       disp_branch_id,
    input  logic                  disp_pred_taken,
    input  logic [31:0]           disp_pred_target,
    input  logic                  res_valid_jump,
    input  logic                  res_jump_taken,
    input  logic [31:0]           res_jump_address,
    input  logic [31:0]           res_orig_pc,
    input  logic [ID_W-1:0]       res_branch_id,
    input  logic                  res_csr_branch,
    input  logic                  global_flush,
    output logic                  redirect_valid,
    output logic [31:0]           redirect_pc,
    output logic [ID_W-1:0]       flush_branch_id,
    output logic                  upd_valid,
    input  logic                  upd_ready,
    output logic [31:0]           upd_pc,
    output logic [31:0]           upd_target,
    output logic                  upd_taken,
    output logic                  upd_mispred,
    output logic [DROP_CNT_W-1:0] drop_cnt
);
    bru_pred_entry_t       tbl_q [NUM_BR_IDS];
    bru_pred_entry_t       tbl_d [NUM_BR_IDS];
    bru_pred_entry_t       res_ent;
    logic                  mispred;
    logic                  redirect_valid_q, redirect_valid_d;
    logic [31:0]           redirect_pc_q, redirect_pc_d;
    logic [ID_W-1:0]       flush_id_q;
    logic [DROP_CNT_W-1:0] drop_cnt_q;
    bru_upd_rec_t          push_rec, head_rec;
    logic                  fifo_push, fifo_pop, fifo_full, fifo_empty, drop;

    // Resolve sees the pre-edge table contents, so a same-cycle dispatch to
    // the same tag cannot affect this comparison.
    always_comb begin
        res_ent = tbl_q[res_branch_id];
        if (!res_ent.valid) res_ent = '0;
    end

    assign mispred          = bru_is_mispred(res_ent, res_jump_taken, res_jump_address, res_csr_branch);
    assign redirect_valid_d = res_valid_jump & mispred & ~global_flush;
    assign redirect_pc_d    = (res_jump_taken | res_csr_branch) ? res_jump_address
                                                                : res_orig_pc + 32'd4;

    // Priority: global flush > dispatch write > resolve invalidate.
    always_comb begin
        for (int i = 0; i < NUM_BR_IDS; i++) tbl_d[i] = tbl_q[i];
        if (global_flush) begin
            for (int i = 0; i < NUM_BR_IDS; i++) tbl_d[i].valid = 1'b0;
        end else begin
            if (res_valid_jump) tbl_d[res_branch_id].valid = 1'b0;
            if (disp_valid)     tbl_d[disp_branch_id] = '{valid: 1'b1,
                                                          pred_taken: disp_pred_taken,
                                                          pred_target: disp_pred_target};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_BR_IDS; i++) tbl_q[i] <= '0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
            flush_id_q       <= '0;
            drop_cnt_q       <= '0;
        end else begin
            for (int i = 0; i < NUM_BR_IDS; i++) tbl_q[i] <= tbl_d[i];
            redirect_valid_q <= redirect_valid_d;
            // Address/tag hold their last value between pulses.
            if (redirect_valid_d) begin
                redirect_pc_q <= redirect_pc_d;
                flush_id_q    <= res_branch_id;
            end
            if (drop && !(&drop_cnt_q)) drop_cnt_q <= drop_cnt_q + 1'b1;
        end
    end

    // CSR redirects are not predictor-trainable, so they never enter the FIFO.
    assign fifo_push = res_valid_jump & ~res_csr_branch;
    assign fifo_pop  = upd_valid & upd_ready;
    assign drop      = fifo_push & fifo_full & ~fifo_pop;
    assign push_rec  = '{pc: res_orig_pc, target: res_jump_address,
                         taken: res_jump_taken, mispred: mispred};

    bru_upd_fifo #(
        .T     (bru_upd_rec_t),
        .DEPTH (UPD_DEPTH)
    ) u_upd_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (fifo_push),
        .pop_i   (fifo_pop),
        .wdata_i (push_rec),
        .rdata_o (head_rec),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    assign redirect_valid  = redirect_valid_q;
    assign redirect_pc     = redirect_pc_q;
    assign flush_branch_id = flush_id_q;
    assign upd_valid       = ~fifo_empty;
    assign upd_pc          = head_rec.pc;
    assign upd_target      = head_rec.target;
    assign upd_taken       = head_rec.taken;
    assign upd_mispred     = head_rec.mispred;
    assign drop_cnt        = drop_cnt_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
module tb_branch_resolve_unit;

    localparam int DW = 3;  // narrow drop counter so saturation is reachable

    logic          clk = 1'b0;
    logic          rst_n;
    logic          disp_valid, disp_pred_taken;
    logic [1:0]    disp_branch_id, res_branch_id, flush_branch_id;
    logic [31:0]   disp_pred_target, res_jump_address, res_orig_pc;
    logic          res_valid_jump, res_jump_taken, res_csr_branch, global_flush;
    logic          redirect_valid, upd_valid, upd_ready, upd_taken, upd_mispred;
    logic [31:0]   redirect_pc, upd_pc, upd_target;
    logic [DW-1:0] drop_cnt;

    branch_resolve_unit #(.NUM_BR_IDS(4), .UPD_DEPTH(4), .DROP_CNT_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .disp_valid(disp_valid), .disp_branch_id(disp_branch_id),
        .disp_pred_taken(disp_pred_taken), .disp_pred_target(disp_pred_target),
        .res_valid_jump(res_valid_jump), .res_jump_taken(res_jump_taken),
        .res_jump_address(res_jump_address), .res_orig_pc(res_orig_pc),
        .res_branch_id(res_branch_id), .res_csr_branch(res_csr_branch),
        .global_flush(global_flush),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .flush_branch_id(flush_branch_id),
        .upd_valid(upd_valid), .upd_ready(upd_ready), .upd_pc(upd_pc),
        .upd_target(upd_target), .upd_taken(upd_taken), .upd_mispred(upd_mispred),
        .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    int n_pass = 0, n_tot = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        disp_valid = 0; disp_branch_id = 0; disp_pred_taken = 0; disp_pred_target = 0;
        res_valid_jump = 0; res_jump_taken = 0; res_jump_address = 0; res_orig_pc = 0;
        res_branch_id = 0; res_csr_branch = 0; global_flush = 0;
    endtask

    task automatic do_reset();
        idle();
        upd_ready = 0;
        rst_n = 0;
        tick(); tick();
        rst_n = 1;
    endtask

    task automatic resolve(input logic [1:0] id, input logic tk, input logic [31:0] addr,
                           input logic [31:0] pc, input logic csr);
        res_valid_jump = 1; res_branch_id = id; res_jump_taken = tk;
        res_jump_address = addr; res_orig_pc = pc; res_csr_branch = csr;
    endtask

    task automatic dispatch(input logic [1:0] id, input logic pt, input logic [31:0] tg);
        disp_valid = 1; disp_branch_id = id; disp_pred_taken = pt; disp_pred_target = tg;
    endtask

    // Directed vectors: optional dispatch, then a resolve, then the expected
    // redirect and training record.
    typedef struct packed {
        logic        dv;  logic [1:0] did; logic dpt; logic [31:0] dtg;
        logic [1:0]  rid; logic tk; logic [31:0] addr; logic [31:0] pc; logic csr;
        logic        erv; logic [31:0] epc; logic eupd; logic emis;
    } vec_t;
    vec_t vecs [7];

    // Reference model state
    typedef struct { logic [31:0] pc, tg; logic tk, mis; } mrec_t;
    bit          mv [4];
    bit          mpt [4];
    logic [31:0] mtg [4];
    mrec_t       mq [$];
    int          mdrop;
    bit          erv;
    logic [31:0] epc;
    logic [1:0]  eid;

    initial begin
        vecs[0] = '{1'b1, 2'd1, 1'b1, 32'h100,  2'd1, 1'b1, 32'h100,  32'h10,       1'b0, 1'b0, 32'h0,    1'b1, 1'b0};
        vecs[1] = '{1'b1, 2'd2, 1'b0, 32'h0,    2'd2, 1'b1, 32'h2000, 32'h40,       1'b0, 1'b1, 32'h2000, 1'b1, 1'b1};
        vecs[2] = '{1'b1, 2'd0, 1'b1, 32'h80,   2'd0, 1'b0, 32'h1234, 32'hFFFFFFFC, 1'b0, 1'b1, 32'h0,    1'b1, 1'b1};
        vecs[3] = '{1'b0, 2'd0, 1'b0, 32'h0,    2'd3, 1'b0, 32'h800,  32'h50,       1'b1, 1'b1, 32'h800,  1'b0, 1'b0};
        vecs[4] = '{1'b1, 2'd3, 1'b1, 32'h300,  2'd3, 1'b1, 32'h304,  32'h60,       1'b0, 1'b1, 32'h304,  1'b1, 1'b1};
        vecs[5] = '{1'b0, 2'd0, 1'b0, 32'h0,    2'd1, 1'b1, 32'h500,  32'h70,       1'b0, 1'b1, 32'h500,  1'b1, 1'b1};
        vecs[6] = '{1'b0, 2'd0, 1'b0, 32'h0,    2'd2, 1'b0, 32'h0,    32'h80,       1'b0, 1'b0, 32'h0,    1'b1, 1'b0};

        do_reset();
        chk("rst redirect_valid", 32'(redirect_valid), 0);
        chk("rst redirect_pc", redirect_pc, 0);
        chk("rst upd_valid", 32'(upd_valid), 0);
        chk("rst upd_pc", upd_pc, 0);
        chk("rst drop_cnt", 32'(drop_cnt), 0);

        // ---- table-driven vectors ----
        foreach (vecs[i]) begin
            if (vecs[i].dv) begin
                dispatch(vecs[i].did, vecs[i].dpt, vecs[i].dtg);
                tick();
                idle();
            end
            resolve(vecs[i].rid, vecs[i].tk, vecs[i].addr, vecs[i].pc, vecs[i].csr);
            tick();
            idle();
            chk($sformatf("v%0d redirect_valid", i), 32'(redirect_valid), 32'(vecs[i].erv));
            if (vecs[i].erv) begin
                chk($sformatf("v%0d redirect_pc", i), redirect_pc, vecs[i].epc);
                chk($sformatf("v%0d flush_id", i), 32'(flush_branch_id), 32'(vecs[i].rid));
            end
            chk($sformatf("v%0d upd_valid", i), 32'(upd_valid), 32'(vecs[i].eupd));
            if (vecs[i].eupd) begin
                chk($sformatf("v%0d upd_pc", i), upd_pc, vecs[i].pc);
                chk($sformatf("v%0d upd_target", i), upd_target, vecs[i].addr);
                chk($sformatf("v%0d upd_taken", i), 32'(upd_taken), 32'(vecs[i].tk));
                chk($sformatf("v%0d upd_mispred", i), 32'(upd_mispred), 32'(vecs[i].emis));
            end
            upd_ready = 1;
            tick();
            upd_ready = 0;
            chk($sformatf("v%0d pulse ends", i), 32'(redirect_valid), 0);
            chk($sformatf("v%0d drained", i), 32'(upd_valid), 0);
        end

        // ---- same-cycle dispatch + resolve on one tag ----
        dispatch(2'd1, 1'b1, 32'h700);
        resolve(2'd1, 1'b1, 32'h700, 32'h90, 1'b0);
        tick();
        idle();
        chk("same-cycle uses old entry", 32'(redirect_valid), 1);
        chk("same-cycle redirect_pc", redirect_pc, 32'h700);
        resolve(2'd1, 1'b1, 32'h700, 32'h90, 1'b0);
        tick();
        idle();
        chk("dispatch write wins", 32'(redirect_valid), 0);
        upd_ready = 1; tick(); tick(); upd_ready = 0;
        chk("same-cycle drained", 32'(upd_valid), 0);

        // ---- global flush ----
        dispatch(2'd2, 1'b1, 32'h40); tick();
        dispatch(2'd0, 1'b0, 32'h0);  tick();
        idle();
        dispatch(2'd3, 1'b1, 32'h500);
        resolve(2'd0, 1'b1, 32'h900, 32'h0, 1'b0);
        global_flush = 1;
        tick();
        idle();
        chk("flush suppresses redirect", 32'(redirect_valid), 0);
        chk("flush keeps fifo push", 32'(upd_valid), 1);
        chk("flush fifo record pc", upd_pc, 32'h0);
        resolve(2'd2, 1'b0, 32'h0, 32'h10, 1'b0);
        tick();
        chk("flush invalidated id2", 32'(redirect_valid), 0);
        resolve(2'd3, 1'b0, 32'h0, 32'h14, 1'b0);
        tick();
        idle();
        chk("flush beats dispatch id3", 32'(redirect_valid), 0);
        upd_ready = 1; tick(); tick(); tick(); upd_ready = 0;
        chk("flush seq drained", 32'(upd_valid), 0);

        // ---- full FIFO: 6 pushes into 4 entries ----
        do_reset();
        for (int i = 0; i < 6; i++) begin
            resolve(2'(i), 1'b1, 32'h2000 + i, 32'h1000 + 4 * i, 1'b0);
            tick();
        end
        idle();
        chk("full drop_cnt", 32'(drop_cnt), 2);
        chk("full head pc", upd_pc, 32'h1000);
        tick();
        chk("head stable while stalled", upd_pc, 32'h1000);
        chk("head target", upd_target, 32'h2000);
        resolve(2'd2, 1'b1, 32'h2006, 32'h1018, 1'b0);
        upd_ready = 1;
        tick();
        idle();
        chk("push+pop at full no drop", 32'(drop_cnt), 2);
        begin
            logic [31:0] order [4];
            order[0] = 32'h1004; order[1] = 32'h1008; order[2] = 32'h100C; order[3] = 32'h1018;
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("drain %0d valid", i), 32'(upd_valid), 1);
                chk($sformatf("drain %0d pc", i), upd_pc, order[i]);
                tick();
            end
        end
        chk("drain empty", 32'(upd_valid), 0);
        tick();
        chk("pop when empty ignored", 32'(upd_valid), 0);
        upd_ready = 0;

        // ---- randomized against reference model ----
        do_reset();
        foreach (mv[k]) begin mv[k] = 0; mpt[k] = 0; mtg[k] = 0; end
        mq.delete();
        mdrop = 0;
        erv = 0; epc = 0; eid = 0;
        for (int i = 0; i < 3000; i++) begin
            bit pt, mis, full, pop;
            logic [31:0] tg;
            int bias;
            bias = (i / 150) % 4;
            disp_valid       = 1'($urandom % 2);
            disp_branch_id   = 2'($urandom);
            disp_pred_taken  = 1'($urandom % 2);
            disp_pred_target = ($urandom % 2) ? 32'h100 : 32'h200;
            res_valid_jump   = ($urandom % 3) != 0;
            res_branch_id    = 2'($urandom);
            res_jump_taken   = 1'($urandom % 2);
            res_jump_address = ($urandom % 2) ? 32'h100 : 32'h200;
            res_orig_pc      = $urandom;
            res_csr_branch   = ($urandom % 16) == 0;
            global_flush     = ($urandom % 20) == 0;
            upd_ready        = int'($urandom % 4) < bias;

            pt  = mv[res_branch_id] ? mpt[res_branch_id] : 1'b0;
            tg  = mv[res_branch_id] ? mtg[res_branch_id] : 32'h0;
            mis = res_csr_branch || (pt != res_jump_taken) ||
                  (res_jump_taken && pt && tg != res_jump_address);
            erv = res_valid_jump && mis && !global_flush;
            if (erv) begin
                epc = (res_jump_taken || res_csr_branch) ? res_jump_address : res_orig_pc + 32'd4;
                eid = res_branch_id;
            end
            full = mq.size() == 4;
            pop  = mq.size() > 0 && upd_ready;
            if (pop) void'(mq.pop_front());
            if (res_valid_jump && !res_csr_branch) begin
                if (!full || pop)
                    mq.push_back('{pc: res_orig_pc, tg: res_jump_address,
                                   tk: res_jump_taken, mis: mis});
                else if (mdrop < 7)
                    mdrop++;
            end
            if (global_flush) begin
                foreach (mv[k]) mv[k] = 0;
            end else begin
                if (res_valid_jump) mv[res_branch_id] = 0;
                if (disp_valid) begin
                    mv[disp_branch_id]  = 1;
                    mpt[disp_branch_id] = disp_pred_taken;
                    mtg[disp_branch_id] = disp_pred_target;
                end
            end

            tick();
            chk("rnd redirect_valid", 32'(redirect_valid), 32'(erv));
            if (erv) begin
                chk("rnd redirect_pc", redirect_pc, epc);
                chk("rnd flush_id", 32'(flush_branch_id), 32'(eid));
            end
            chk("rnd upd_valid", 32'(upd_valid), 32'(mq.size() != 0));
            if (mq.size() != 0) begin
                chk("rnd upd_pc", upd_pc, mq[0].pc);
                chk("rnd upd_target", upd_target, mq[0].tg);
                chk("rnd upd_taken", 32'(upd_taken), 32'(mq[0].tk));
                chk("rnd upd_mispred", 32'(upd_mispred), 32'(mq[0].mis));
            end
            chk("rnd drop_cnt", 32'(drop_cnt), 32'(mdrop));
        end

        // ---- async reset while the FIFO holds data ----
        idle();
        upd_ready = 0;
        resolve(2'd1, 1'b1, 32'hABC, 32'h123, 1'b0);
        tick(); tick();
        idle();
        chk("pre-reset fifo holds data", 32'(upd_valid), 1);
        #2;
        rst_n = 0;
        #1;
        chk("async rst upd_valid", 32'(upd_valid), 0);
        chk("async rst upd_pc", upd_pc, 0);
        chk("async rst upd_target", upd_target, 0);
        chk("async rst redirect_valid", 32'(redirect_valid), 0);
        chk("async rst redirect_pc", redirect_pc, 0);
        chk("async rst drop_cnt", 32'(drop_cnt), 0);
        tick();
        rst_n = 1;

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
